float_rounder: RTL

- Back-end consumer of the FPU arithmetic units' unrounded result bundle: mantissa, exponent, sign, round bit, sticky bit, skip_round, IV and rounding mode.
- Denormalizes tiny results with an iterative 1-bit/cycle shifter, applies IEEE-754 rounding in the five RISC-V modes, detects overflow and underflow, and packs the binary32 word plus fflags.
- Sits between the arithmetic units (e.g. float_multiplier) and FPU writeback, using the same valid/ready handshake.

---
 rtl/float_rounder_if.sv | 25 ++
 rtl/float_rounder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/float_rounder_if.sv
// float_rounder_if: result-bundle handshake between arithmetic units, rounder and writeback
interface float_rounder_if;
  logic        valid_in;
  logic        ready_out;
  logic        valid_out;
  logic        ready_in;
  logic [23:0] man_in;
  logic [9:0]  exp_in;
  logic        sgn_in;
  logic        round_bit;
  logic        sticky_bit;
  logic        skip_round;
  logic        IV;
  logic [2:0]  rm;
  logic [31:0] float_out;
  logic [4:0]  fflags;
  modport master(
    output valid_in, man_in, exp_in, sgn_in, round_bit, sticky_bit, skip_round, IV, rm, ready_in,
    input  ready_out, valid_out, float_out, fflags
  );
  modport slave(
    input  valid_in, man_in, exp_in, sgn_in, round_bit, sticky_bit, skip_round, IV, rm, ready_in,
    output ready_out, valid_out, float_out, fflags
  );
endinterface

// File: rtl/float_rounder.sv
// float_rounder: denormalizes, rounds (RISC-V modes) and packs binary32 results with fflags
module float_rounder #(
  parameter int MAX_SHIFT = 25
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  float_rounder_if.slave io
);
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  localparam logic signed [10:0] LIM = 11'(1 - MAX_SHIFT);
  state_t             state_q, state_d;
  logic [23:0]        man_q, man_d, man_r;
  logic signed [10:0] exp_q, exp_d, exp_r, exp_s, exp_x;
  logic               sgn_q, sgn_d, rnd_q, rnd_d, stk_q, stk_d, tiny_q, tiny_d;
  logic [2:0]         rm_q, rm_d;
  logic [31:0]        out_q, out_d;
  logic [4:0]         flg_q, flg_d;
  logic [24:0]        sum;
  logic               inc, nx, of, inf;
  assign io.ready_out = state_q == IDLE;
  assign io.valid_out = state_q == DONE;
  assign io.float_out = out_q;
  assign io.fflags    = flg_q;
  assign exp_x = {io.exp_in[9], io.exp_in};
  assign exp_s = exp_q + 11'sd1;
  assign nx    = rnd_q | stk_q;
  assign inc   = rm_q == 3'd0 ? rnd_q & (stk_q | man_q[0]) :
                 rm_q == 3'd2 ? sgn_q & nx :
                 rm_q == 3'd3 ? !sgn_q & nx :
                 rm_q == 3'd4 ? rnd_q : 1'b0;
  assign sum   = {1'b0, man_q} + {24'd0, inc};
  assign man_r = sum[24] ? sum[24:1] : sum[23:0];
  assign exp_r = exp_q + (sum[24] ? 11'sd1 : 11'sd0);
  assign of    = exp_r >= 11'sd255;
  assign inf   = rm_q == 3'd0 || rm_q == 3'd4 || (rm_q == 3'd3 && !sgn_q) || (rm_q == 3'd2 && sgn_q);
  always_comb begin
    state_d = state_q;
    man_d   = man_q;
    exp_d   = exp_q;
    sgn_d   = sgn_q;
    rnd_d   = rnd_q;
    stk_d   = stk_q;
    tiny_d  = tiny_q;
    rm_d    = rm_q;
    out_d   = out_q;
    flg_d   = flg_q;
    case (state_q)
      IDLE: if (io.valid_in) begin
        man_d  = io.man_in;
        exp_d  = exp_x;
        sgn_d  = io.sgn_in;
        rnd_d  = io.round_bit;
        stk_d  = io.sticky_bit;
        rm_d   = io.rm;
        tiny_d = 1'b0;
        if (io.skip_round) begin
          state_d = DONE;
          out_d   = {io.sgn_in, io.exp_in[7:0], io.man_in[22:0]};
          flg_d   = {io.IV, 4'b0};
        end else if (io.rm > 3'd4) begin
          state_d = DONE;
          out_d   = 32'h7fc00000;
          flg_d   = 5'b10000;
        end else if (exp_x <= 11'sd0 && |io.man_in) begin
          state_d = SHIFT;
          tiny_d  = 1'b1;
        end else begin
          state_d = ROUND;
        end
      end
      SHIFT: if (exp_q < LIM) begin
        stk_d   = |{man_q, rnd_q, stk_q};
        man_d   = '0;
        rnd_d   = 1'b0;
        exp_d   = 11'sd1;
        state_d = ROUND;
      end else begin
        stk_d   = stk_q | rnd_q;
        rnd_d   = man_q[0];
        man_d   = man_q >> 1;
        exp_d   = exp_s;
        state_d = exp_s == 11'sd1 ? ROUND : SHIFT;
      end
      ROUND: begin
        state_d = DONE;
        man_d   = man_r;
        exp_d   = exp_r;
        out_d   = of ? {sgn_q, inf ? 31'h7f800000 : 31'h7f7fffff}
                     : {sgn_q, man_r[23] ? exp_r[7:0] : 8'd0, man_r[22:0]};
        flg_d   = {2'b00, of, tiny_q & nx, nx | of};
      end
      DONE: state_d = io.ready_in ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state_q <= IDLE;
      man_q   <= '0;
      exp_q   <= '0;
      sgn_q   <= 1'b0;
      rnd_q   <= 1'b0;
      stk_q   <= 1'b0;
      tiny_q  <= 1'b0;
      rm_q    <= '0;
      out_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      man_q   <= man_d;
      exp_q   <= exp_d;
      sgn_q   <= sgn_d;
      rnd_q   <= rnd_d;
      stk_q   <= stk_d;
      tiny_q  <= tiny_d;
      rm_q    <= rm_d;
      out_q   <= out_d;
      flg_q   <= flg_d;
    end
  end
endmodule
